pipe_add: RTL and testbench
===========================

PIPE_ADD -- requirements
Module: pipe_add

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits (>= 2).
REQ-002 SHALL have parameter STAGES, default 4, pipeline depth; WIDTH SHALL be an integer multiple of STAGES; CHUNK = WIDTH/STAGES.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operands a, b, ci present.
REQ-006 SHALL have port in_ready  output  1  pipeline accepts operands this cycle.
REQ-007 SHALL have port a  input  WIDTH  addend.
REQ-008 SHALL have port b  input  WIDTH  addend.
REQ-009 SHALL have port ci  input  1  carry-in.
REQ-010 SHALL have port out_valid  output  1  s holds a completed result.
REQ-011 SHALL have port out_ready  input  1  consumer accepts s this cycle.
REQ-012 SHALL have port s  output  WIDTH+1  sum; s[WIDTH] is carry-out.

Function
REQ-013 SHALL split the addition into STAGES chunks of CHUNK bits; stage k adds bits [k*CHUNK +: CHUNK] of a and b plus the registered carry from stage k-1 (stage 0 uses ci).
REQ-014 SHALL register the inter-stage carry, delay upper operand chunks (skew) and delay lower sum chunks (deskew) so that every result leaves all chunks aligned.
REQ-015 SHALL present s = a + b + ci, zero-extended to WIDTH+1 bits, modulo 2^(WIDTH+1).
REQ-016 SHALL define advance = !out_valid || out_ready; in_ready SHALL equal advance combinationally.
REQ-017 SHALL shift all stages together only when advance = 1; when advance = 0 every stage register, including s and out_valid, SHALL hold.
REQ-018 SHALL capture operands on in_valid && in_ready; a transfer completes on out_valid && out_ready.
REQ-019 SHALL carry a per-stage valid bit; bubbles (in_valid = 0 while advancing) SHALL propagate as invalid stages and never raise out_valid.
REQ-020 SHALL have latency of exactly STAGES cycles from acceptance to out_valid when the consumer does not stall.
REQ-021 SHALL sustain one accepted operation per cycle while out_ready = 1.
REQ-022 SHALL keep s stable while out_valid = 1 and out_ready = 0.
REQ-023 SHALL deliver results in acceptance order, never dropping or duplicating an operation.
REQ-024 SHALL behave, when STAGES = 1, as a single registered WIDTH-bit adder with latency 1.

Reset
REQ-025 SHALL, on rst_n = 0, immediately clear all stage valid bits, out_valid = 0, s = 0, all carry and skew registers = 0.
REQ-026 SHALL discard all in-flight operations on reset mid-operation; no result from before reset SHALL appear afterwards.
REQ-027 SHALL drive in_ready = 1 during and after reset (pipeline empty).

Configuration
REQ-028 SHALL, when macro PIPE_ADD_SUB_EN is defined, add port sub  input  1, captured with the operands; sub = 1 computes a + ~b + 1 (ci ignored) and s[WIDTH] = 1 means no borrow (a >= b unsigned).
REQ-029 SHALL, when PIPE_ADD_SUB_EN is defined, add port ovf  output  1, signed two's-complement overflow of the WIDTH-bit result, aligned with s, held on stall, reset to 0.
REQ-030 SHALL, when PIPE_ADD_SUB_EN is undefined, have neither sub nor ovf and compute only addition per REQ-015.

Verification (WIDTH = 32, STAGES = 4)
REQ-031 SHALL check: reset, then a = 0xFFFFFFFF, b = 0x00000001, ci = 0 accepted at cycle 0, out_ready = 1 -> out_valid at cycle 4, s = 0x1_00000000.
REQ-032 SHALL check: back-to-back a = 1,2,3 and b = 10,20,30 for three cycles -> s = 11, 22, 33 on consecutive cycles 4, 5, 6.
REQ-033 SHALL check: out_ready = 0 for 6 cycles with 5 operations offered -> in_ready = 0 once full, s holds first result, all 5 results delivered in order once out_ready = 1.
REQ-034 SHALL check: rst_n pulsed low while 3 operations in flight -> out_valid = 0 immediately, no stale result ever appears.
REQ-035 SHALL check: carry crossing every chunk boundary, a = 0x00FFFFFF, b = 0x00000000, ci = 1 -> s = 0x0_01000000.
REQ-036 SHALL check with PIPE_ADD_SUB_EN: sub = 1, a = 0x80000000, b = 0x00000001 -> s = 0x1_7FFFFFFF, ovf = 1.

Source files
------------

// File: rtl/pipe_add.sv
// Pipelined carry-chunked adder: STAGES chunks of WIDTH/STAGES bits, ready/valid on both sides.
// Optional subtract mode with signed overflow flag is enabled by defining PIPE_ADD_SUB_EN.
module pipe_add #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
`ifdef PIPE_ADD_SUB_EN
    input  logic             sub,
    output logic             ovf,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   s
);

    localparam int CHUNK = WIDTH / STAGES;

    logic             advance_s;
    logic [WIDTH-1:0] b_eff_s;
    logic             ci_eff_s;

    assign advance_s = !out_valid || out_ready;
    assign in_ready  = advance_s;

`ifdef PIPE_ADD_SUB_EN
    // Subtraction reuses the adder as a + ~b + 1; carry-in is overridden.
    always_comb begin
        b_eff_s  = b;
        ci_eff_s = ci;
        if (sub) begin
            b_eff_s  = ~b;
            ci_eff_s = 1'b1;
        end else begin
            b_eff_s  = b;
            ci_eff_s = ci;
        end
    end
`else
    // Addition only: operands pass straight through.
    always_comb begin
        b_eff_s  = b;
        ci_eff_s = ci;
    end
`endif

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        localparam int SW = (k + 1) * CHUNK;   // sum bits resolved once this stage is loaded
        localparam int RW = WIDTH - SW;        // operand bits still waiting for later stages

        logic [RW+CHUNK-1:0] a_src_s;
        logic [RW+CHUNK-1:0] b_src_s;
        logic                cin_s;
        logic                vin_s;
        logic [CHUNK:0]      part_s;
        logic [SW-1:0]       sum_nxt_s;
        logic [SW-1:0]       sum_r;
        logic                carry_r;
        logic                valid_r;

        if (k == 0) begin : g_src
            assign a_src_s   = a;
            assign b_src_s   = b_eff_s;
            assign cin_s     = ci_eff_s;
            assign vin_s     = in_valid;
            assign sum_nxt_s = part_s[CHUNK-1:0];
        end else begin : g_src
            assign a_src_s   = g_stg[k-1].g_rem.a_rem_r;
            assign b_src_s   = g_stg[k-1].g_rem.b_rem_r;
            assign cin_s     = g_stg[k-1].carry_r;
            assign vin_s     = g_stg[k-1].valid_r;
            assign sum_nxt_s = {part_s[CHUNK-1:0], g_stg[k-1].sum_r};
        end

        assign part_s = {1'b0, a_src_s[CHUNK-1:0]} + {1'b0, b_src_s[CHUNK-1:0]}
                      + {{CHUNK{1'b0}}, cin_s};

        // Resolved sum chunks, inter-stage carry and stage valid; all stages move together.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sum_r   <= '0;
                carry_r <= 1'b0;
                valid_r <= 1'b0;
            end else if (advance_s) begin
                sum_r   <= sum_nxt_s;
                carry_r <= part_s[CHUNK];
                valid_r <= vin_s;
            end
        end

        if (k < STAGES - 1) begin : g_rem
            logic [RW-1:0] a_rem_r;
            logic [RW-1:0] b_rem_r;

            // Skew: the low chunk has been consumed, upper chunks wait for their stage.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_rem_r <= '0;
                    b_rem_r <= '0;
                end else if (advance_s) begin
                    a_rem_r <= a_src_s[RW+CHUNK-1:CHUNK];
                    b_rem_r <= b_src_s[RW+CHUNK-1:CHUNK];
                end
            end
        end
    end

    assign out_valid = g_stg[STAGES-1].valid_r;
    assign s         = {g_stg[STAGES-1].carry_r, g_stg[STAGES-1].sum_r};

`ifdef PIPE_ADD_SUB_EN
    logic ovf_r;

    // Signed overflow: both operand MSBs agree but the result MSB differs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_r <= 1'b0;
        end else if (advance_s) begin
            ovf_r <= (g_stg[STAGES-1].a_src_s[CHUNK-1] == g_stg[STAGES-1].b_src_s[CHUNK-1])
                  && (g_stg[STAGES-1].part_s[CHUNK-1] != g_stg[STAGES-1].a_src_s[CHUNK-1]);
        end
    end

    assign ovf = ovf_r;
`endif

endmodule

// File: tb/tb_pipe_add.sv
// Directed-vector bench for pipe_add (WIDTH = 32, STAGES = 4).
module tb_pipe_add;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        ci;
    logic        out_valid;
    logic        out_ready;
    logic [32:0] s;
`ifdef PIPE_ADD_SUB_EN
    logic        sub;
    logic        ovf;
`endif

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] va [5] = '{32'h12345678, 32'hFFFF0000, 32'h0000FFFF, 32'h80000000, 32'hDEADBEEF};
    logic [31:0] vb [5] = '{32'h11111111, 32'h00010000, 32'h00000001, 32'h80000001, 32'h21524111};
    logic        vc [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [32:0] ve [5] = '{33'h0_23456789, 33'h1_00000001, 33'h0_00010000,
                            33'h1_00000002, 33'h1_00000001};

    always #5 clk = ~clk;

    pipe_add #(.WIDTH(32), .STAGES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .ci        (ci),
`ifdef PIPE_ADD_SUB_EN
        .sub       (sub),
        .ovf       (ovf),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s)
    );

    task automatic chk_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_one(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                           input logic tci, input logic [32:0] texp);
        int lat;
        out_ready = 1'b1;
        a         = ta;
        b         = tb;
        ci        = tci;
        in_valid  = 1'b1;
        #1;
        chk_value({tag, "_rdy"}, 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        lat      = 1;
        while (!out_valid && lat < 12) begin
            tick();
            lat++;
        end
        chk_value({tag, "_lat"}, 64'(lat), 64'd4);
        chk_value({tag, "_s"}, 64'(s), 64'(texp));
        tick();
        chk_value({tag, "_bubble"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        int nxt;
        int rcv;
        logic acc;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = 32'd0;
        b         = 32'd0;
        ci        = 1'b0;
`ifdef PIPE_ADD_SUB_EN
        sub       = 1'b0;
`endif
        #3;
        chk_value("rst_out_valid", 64'(out_valid), 64'd0);
        chk_value("rst_s", 64'(s), 64'd0);
        chk_value("rst_in_ready", 64'(in_ready), 64'd1);
        #9;
        rst_n = 1'b1;
        tick();
        chk_value("post_rst_in_ready", 64'(in_ready), 64'd1);

        run_one("wrap", 32'hFFFFFFFF, 32'h00000001, 1'b0, 33'h1_00000000);
        run_one("chunk_carry", 32'h00FFFFFF, 32'h00000000, 1'b1, 33'h0_01000000);

        // Back-to-back: three accepts, results on three consecutive cycles.
        for (int i = 1; i <= 3; i++) begin
            a        = 32'(i);
            b        = 32'(10 * i);
            ci       = 1'b0;
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        tick();
        chk_value("b2b_v0", 64'(out_valid), 64'd1);
        chk_value("b2b_s0", 64'(s), 64'd11);
        tick();
        chk_value("b2b_v1", 64'(out_valid), 64'd1);
        chk_value("b2b_s1", 64'(s), 64'd22);
        tick();
        chk_value("b2b_v2", 64'(out_valid), 64'd1);
        chk_value("b2b_s2", 64'(s), 64'd33);
        tick();
        chk_value("b2b_drain", 64'(out_valid), 64'd0);

        // Back-pressure: consumer stalls for 6 cycles while 5 operations are offered.
        nxt = 0;
        rcv = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            out_ready = (cyc >= 6);
            in_valid  = (nxt < 5);
            a  = (nxt < 5) ? va[nxt] : 32'd0;
            b  = (nxt < 5) ? vb[nxt] : 32'd0;
            ci = (nxt < 5) ? vc[nxt] : 1'b0;
            #1;
            if (out_valid && !out_ready) begin
                chk_value($sformatf("stall_in_ready_c%0d", cyc), 64'(in_ready), 64'd0);
                chk_value($sformatf("stall_hold_c%0d", cyc), 64'(s), 64'(ve[0]));
            end
            if (out_valid && out_ready) begin
                if (rcv < 5) chk_value($sformatf("order_%0d", rcv), 64'(s), 64'(ve[rcv]));
                else         chk_value("extra_result", 64'(rcv), 64'd4);
                rcv++;
            end
            acc = in_valid && in_ready;
            tick();
            if (acc) nxt++;
        end
        in_valid = 1'b0;
        chk_value("all_delivered", 64'(rcv), 64'd5);
        chk_value("all_accepted", 64'(nxt), 64'd5);

        // Reset with three operations in flight.
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a        = 32'h0000_1000 + 32'(i);
            b        = 32'h0000_0100;
            ci       = 1'b0;
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk_value("midrst_out_valid", 64'(out_valid), 64'd0);
        chk_value("midrst_s", 64'(s), 64'd0);
        chk_value("midrst_in_ready", 64'(in_ready), 64'd1);
        tick();
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk_value($sformatf("no_stale_%0d", i), 64'(out_valid), 64'd0);
        end

`ifdef PIPE_ADD_SUB_EN
        sub = 1'b1;
        run_one("sub_ovf", 32'h80000000, 32'h00000001, 1'b0, 33'h1_7FFFFFFF);
        tick();
        chk_value("sub_ovf_flag_held", 64'(ovf), 64'd1);
        sub = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
